// File: rtl/ocd_mem_dump_tx.sv
// ocd_mem_dump_tx: reads a block of words over the OCD memory-read port and sends them as a checksummed 8N1 UART frame.
// Latency: TXD start bit one clock after start is accepted; each byte takes 10*BAUD_PERIOD clocks; a word read waits at most READ_TIMEOUT clocks.
// Backpressure: none. start is ignored while busy, and a missing read response is replaced by 32'hDEADBEEF with read_error set.
//
// Ports:
//   clk, reset_n            : clock and synchronous active-low reset
//   start/start_addr/word_count : dump request (accepted only when idle)
//   busy, done, read_error  : status (done is a one-cycle pulse; read_error is sticky per dump)
//   mem_read_enable/addr    : one-cycle read request; mem_enable_in/mem_word_in return the data
//   TXD, uart_tx_sel_dump   : registered serial output and TX mux select
//
// Frame: 5A [hdr] {word bytes LE}* csum. The csum is the 8-bit sum of every byte except 5A.
// Optional macro DUMP_ADDR_HEADER_EN adds a 6-byte header: start_addr as 32-bit LE, then word_count as 16-bit LE.
module ocd_mem_dump_tx #(
  parameter int BAUD_PERIOD  = 217,
  parameter int ADDR_WIDTH   = 14,
  parameter int XLEN         = 32,
  parameter int READ_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [15:0]           word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  read_error,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic                  mem_enable_in,
  input  logic [XLEN-1:0]       mem_word_in,
  output logic                  TXD,
  output logic                  uart_tx_sel_dump
);

  localparam int              BW        = $clog2(BAUD_PERIOD + 1);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_PERIOD - 1);
  localparam int              TW        = $clog2(READ_TIMEOUT + 1);
  localparam logic [TW-1:0]   WAIT_LAST = TW'(READ_TIMEOUT - 1);
  localparam logic [XLEN-1:0] DEAD_WORD = XLEN'(32'hDEADBEEF);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_HDR, S_REQ, S_WAIT, S_SEND, S_CSUM, S_FIN
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_remain;
  logic [XLEN-1:0]       r_word;
  logic [7:0]            r_csum;
  logic [2:0]            r_idx;
  logic                  r_act;
  logic                  r_txd;
  logic [8:0]            r_shift;
  logic [3:0]            r_bit;
  logic [BW-1:0]         r_baud;
  logic [TW-1:0]         r_wait;
  logic                  r_read_error;

  logic                  w_byte_done, w_last, w_timeout, w_load, w_nxt_tx;
  logic [2:0]            w_nxt_idx;
  logic [7:0]            w_nxt_byte;
  logic [XLEN-1:0]       w_word;
`ifdef DUMP_ADDR_HEADER_EN
  logic [47:0]           w_hdr;
  assign w_hdr = {r_remain, 32'(r_addr)};
`endif

  // Stop bit of the current byte ends on this clock.
  assign w_byte_done = r_act && (r_baud == BAUD_LAST) && (r_bit == 4'd9);
  assign w_timeout   = (r_state == S_WAIT) && !mem_enable_in && (r_wait == WAIT_LAST);
  // In WAIT the word is taken straight from the port so SEND can load byte 0 on the capture edge.
  assign w_word      = (r_state == S_WAIT) ? (mem_enable_in ? mem_word_in : DEAD_WORD) : r_word;

  always_comb begin
    case (r_state)
      S_HDR:   w_last = (r_idx == 3'd5);
      S_SEND:  w_last = (r_idx == 3'd3);
      default: w_last = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_SYNC;
      S_SYNC: if (w_byte_done) begin
`ifdef DUMP_ADDR_HEADER_EN
        w_state_nxt = S_HDR;
`else
        w_state_nxt = (r_remain == 16'd0) ? S_CSUM : S_REQ;
`endif
      end
      S_HDR:  if (w_byte_done && w_last) w_state_nxt = (r_remain == 16'd0) ? S_CSUM : S_REQ;
      S_REQ:  w_state_nxt = S_WAIT;
      S_WAIT: if (mem_enable_in || w_timeout) w_state_nxt = S_SEND;
      S_SEND: if (w_byte_done && w_last) w_state_nxt = (r_remain == 16'd1) ? S_CSUM : S_REQ;
      S_CSUM: if (w_byte_done) w_state_nxt = S_FIN;
      S_FIN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy             = (r_state != S_IDLE) && (r_state != S_FIN);
    uart_tx_sel_dump = busy;
    done             = (r_state == S_FIN);
    mem_read_enable  = (r_state == S_REQ);
  end
  assign mem_read_addr = r_addr;
  assign TXD           = r_txd;
  assign read_error    = r_read_error;

  // A new byte is loaded when entering a transmitting state, or straight after the stop bit
  // when the state still has bytes left, so bytes within a frame run back-to-back.
  assign w_nxt_tx  = (w_state_nxt == S_SYNC) || (w_state_nxt == S_HDR) ||
                     (w_state_nxt == S_SEND) || (w_state_nxt == S_CSUM);
  assign w_load    = w_nxt_tx && ((w_state_nxt != r_state) || (w_byte_done && !w_last));
  assign w_nxt_idx = (w_state_nxt != r_state) ? 3'd0 : r_idx + 3'd1;

  always_comb begin
    case (w_state_nxt)
      S_SYNC:  w_nxt_byte = 8'h5A;
`ifdef DUMP_ADDR_HEADER_EN
      S_HDR:   w_nxt_byte = w_hdr[8*w_nxt_idx +: 8];
`endif
      S_SEND:  w_nxt_byte = w_word[8*w_nxt_idx[1:0] +: 8];
      S_CSUM:  w_nxt_byte = r_csum;
      default: w_nxt_byte = 8'hFF;
    endcase
  end

  // Datapath and UART shifter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr       <= '0;
      r_remain     <= '0;
      r_word       <= '0;
      r_csum       <= '0;
      r_idx        <= '0;
      r_act        <= 1'b0;
      r_txd        <= 1'b1;
      r_shift      <= '1;
      r_bit        <= '0;
      r_baud       <= '0;
      r_wait       <= '0;
      r_read_error <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_addr       <= start_addr;
        r_remain     <= word_count;
        r_csum       <= '0;
        r_read_error <= 1'b0;
      end
      if (r_state == S_REQ)       r_wait <= '0;
      else if (r_state == S_WAIT) r_wait <= r_wait + 1'b1;
      if (r_state == S_WAIT && w_state_nxt == S_SEND) begin
        r_word <= w_word;
        if (w_timeout) r_read_error <= 1'b1;
      end
      if (r_state == S_SEND && w_byte_done && w_last) begin
        r_addr   <= r_addr + 1'b1;
        r_remain <= r_remain - 16'd1;
      end

      if (w_load) begin
        r_act   <= 1'b1;
        r_txd   <= 1'b0;
        r_shift <= {1'b1, w_nxt_byte};
        r_bit   <= '0;
        r_baud  <= '0;
        r_idx   <= w_nxt_idx;
        if (w_state_nxt == S_HDR || w_state_nxt == S_SEND) r_csum <= r_csum + w_nxt_byte;
      end else if (r_act) begin
        if (r_baud == BAUD_LAST) begin
          r_baud <= '0;
          if (r_bit == 4'd9) begin
            r_act <= 1'b0;
            r_txd <= 1'b1;
          end else begin
            // shift[8] is the stop bit, reaching TXD as the tenth bit
            r_txd   <= r_shift[0];
            r_shift <= {1'b1, r_shift[8:1]};
            r_bit   <= r_bit + 4'd1;
          end
        end else begin
          r_baud <= r_baud + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ocd_mem_dump_tx.sv
module tb_ocd_mem_dump_tx;
  localparam int BP = 4;
  localparam int AW = 14;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [15:0]   word_count;
  logic          busy, done, read_error, mem_read_enable;
  logic [AW-1:0] mem_read_addr;
  logic          mem_enable_in;
  logic [31:0]   mem_word_in;
  logic          TXD, uart_tx_sel_dump;

  ocd_mem_dump_tx #(.BAUD_PERIOD(BP), .ADDR_WIDTH(AW), .XLEN(32), .READ_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done), .read_error(read_error),
    .mem_read_enable(mem_read_enable), .mem_read_addr(mem_read_addr),
    .mem_enable_in(mem_enable_in), .mem_word_in(mem_word_in),
    .TXD(TXD), .uart_tx_sel_dump(uart_tx_sel_dump)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory with one-cycle read latency
  logic mem_dead = 1'b0;
  function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
    case (a)
      14'h0010: return 32'h04030201;
      14'h0011: return 32'h08070605;
      14'h3FFF: return 32'h11223344;
      14'h0000: return 32'hA0B0C0D0;
      default:  return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    mem_enable_in <= mem_read_enable && !mem_dead;
    mem_word_in   <= mem_read_enable ? mem_rd(mem_read_addr) : 32'h0;
  end

  logic [AW-1:0] rd_q[$];
  int            done_cnt = 0;
  always @(posedge clk) begin
    if (mem_read_enable) rd_q.push_back(mem_read_addr);
    if (done) done_cnt++;
  end

  // UART receiver, sampling mid-bit on falling clock edges
  logic [7:0] rx_q[$];
  int         rx_ferr = 0;
  initial begin : rx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (TXD === 1'b0) begin
        repeat (BP/2) @(negedge clk);
        if (TXD !== 1'b0) rx_ferr++;
        for (int i = 0; i < 8; i++) begin
          repeat (BP) @(negedge clk);
          b[i] = TXD;
        end
        repeat (BP) @(negedge clk);
        if (TXD !== 1'b1) rx_ferr++;
        rx_q.push_back(b);
      end
    end
  end

  typedef struct packed {
    logic [AW-1:0]       addr;
    logic [15:0]         cnt;
    logic                dead;
    logic [4:0]          nbytes;
    logic [0:15][7:0]    bytes;
    logic [1:0]          nreads;
    logic [0:1][AW-1:0]  reads;
    logic                err;
    logic [7:0]          restart_at;
  } vec_t;

  vec_t vecs[6];

  // Left-justify n right-aligned bytes so the first byte lands at index 0.
  function automatic logic [0:15][7:0] pk(input logic [127:0] v, input int n);
    return v << (8 * (16 - n));
  endfunction

  function automatic vec_t mk(input logic [AW-1:0] a, input logic [15:0] c, input logic dead,
                              input logic [127:0] b, input int nb, input logic [1:0] nr,
                              input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                              input logic err, input logic [7:0] rs);
    vec_t v;
    v.addr = a; v.cnt = c; v.dead = dead;
    v.nbytes = 5'(nb); v.bytes = pk(b, nb);
    v.nreads = nr; v.reads[0] = r0; v.reads[1] = r1;
    v.err = err; v.restart_at = rs;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int  cyc, busy_cyc, busy_low;
    bit  seen_done;
    rx_q.delete(); rd_q.delete(); done_cnt = 0; rx_ferr = 0;
    mem_dead = v.dead;
    @(negedge clk);
    start_addr = v.addr; word_count = v.cnt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; busy_cyc = 0; busy_low = 0; seen_done = 0;
    while (!seen_done && cyc < 4000) begin
      if (done) seen_done = 1;
      else if (busy && uart_tx_sel_dump) busy_cyc++;
      else busy_low++;
      if (v.restart_at != 0 && cyc == int'(v.restart_at)) begin
        start = 1'b1; start_addr = 14'h0123; word_count = 16'd7;
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 32'(seen_done), 32'd1);
    repeat (4*BP) @(negedge clk);
    chk({tag, " done_pulses"}, done_cnt, 32'd1);
    chk({tag, " busy_drop"}, busy_low, 32'd0);
    chk({tag, " framing"}, rx_ferr, 32'd0);
    chk({tag, " byte_count"}, rx_q.size(), 32'(v.nbytes));
    for (int i = 0; i < int'(v.nbytes) && i < rx_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), 32'(rx_q[i]), 32'(v.bytes[i]));
    chk({tag, " read_count"}, rd_q.size(), 32'(v.nreads));
    for (int i = 0; i < int'(v.nreads) && i < rd_q.size(); i++)
      chk($sformatf("%s read%0d", tag, i), 32'(rd_q[i]), 32'(v.reads[i]));
    chk({tag, " read_error"}, 32'(read_error), 32'(v.err));
    chk({tag, " idle_after"}, {30'd0, busy, uart_tx_sel_dump}, 32'd0);
    if (v.cnt == 16'd0)
      chk({tag, " frame_clocks"}, busy_cyc, 32'(v.nbytes) * 10 * BP);
  endtask

  initial begin
`ifdef DUMP_ADDR_HEADER_EN
    vecs[0] = mk(14'h0010, 16'd2, 1'b0,
      {8'h5A,8'h10,8'h00,8'h00,8'h00,8'h02,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h36},
      16, 2'd2, 14'h0010, 14'h0011, 1'b0, 8'd0);
    vecs[1] = mk(14'h0005, 16'd0, 1'b0,
      {8'h5A,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00,8'h05}, 8, 2'd0, 14'h0, 14'h0, 1'b0, 8'd0);
    vecs[2] = mk(14'h3FFF, 16'd2, 1'b0,
      {8'h5A,8'hFF,8'h3F,8'h00,8'h00,8'h02,8'h00,8'h44,8'h33,8'h22,8'h11,8'hD0,8'hC0,8'hB0,8'hA0,8'hCA},
      16, 2'd2, 14'h3FFF, 14'h0000, 1'b0, 8'd0);
    vecs[3] = mk(14'h0020, 16'd1, 1'b1,
      {8'h5A,8'h20,8'h00,8'h00,8'h00,8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,8'h59},
      12, 2'd1, 14'h0020, 14'h0, 1'b1, 8'd0);
`else
    vecs[0] = mk(14'h0010, 16'd2, 1'b0,
      {8'h5A,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h24},
      10, 2'd2, 14'h0010, 14'h0011, 1'b0, 8'd0);
    vecs[1] = mk(14'h0005, 16'd0, 1'b0, {8'h5A,8'h00}, 2, 2'd0, 14'h0, 14'h0, 1'b0, 8'd0);
    vecs[2] = mk(14'h3FFF, 16'd2, 1'b0,
      {8'h5A,8'h44,8'h33,8'h22,8'h11,8'hD0,8'hC0,8'hB0,8'hA0,8'h8A},
      10, 2'd2, 14'h3FFF, 14'h0000, 1'b0, 8'd0);
    vecs[3] = mk(14'h0020, 16'd1, 1'b1, {8'h5A,8'hEF,8'hBE,8'hAD,8'hDE,8'h38},
      6, 2'd1, 14'h0020, 14'h0, 1'b1, 8'd0);
`endif
    // Live read after a timed-out dump: read_error must clear.
    vecs[4] = vecs[0];
    // Second start in the middle of the frame must be ignored.
    vecs[5] = vecs[0];
    vecs[5].restart_at = 8'd60;

    reset_n = 1'b0; start = 1'b0; start_addr = '0; word_count = '0;
    repeat (3) @(negedge clk);
    chk("rst TXD", 32'(TXD), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst read_error", 32'(read_error), 32'd0);
    chk("rst mem_read_enable", 32'(mem_read_enable), 32'd0);
    chk("rst mem_read_addr", 32'(mem_read_addr), 32'd0);
    chk("rst tx_sel", 32'(uart_tx_sel_dump), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("v%0d", k));

    // Reset in the middle of the third byte.
    mem_dead = 1'b0;
    @(negedge clk);
    start_addr = 14'h0010; word_count = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25*BP) @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid-reset TXD", 32'(TXD), 32'd1);
    chk("mid-reset busy", 32'(busy), 32'd0);
    chk("mid-reset tx_sel", 32'(uart_tx_sel_dump), 32'd0);
    chk("mid-reset done", 32'(done), 32'd0);
    chk("mid-reset mem_read_enable", 32'(mem_read_enable), 32'd0);
    repeat (12*BP) begin
      @(negedge clk);
      if (TXD !== 1'b1) chk("reset TXD held", 32'(TXD), 32'd1);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(vecs[0], "after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ocd_mem_dump_tx.md
Name: ocd_mem_dump_tx

Overview:
- Readback engine, the reader counterpart to the debug coprocessor's PRAM write path.
- On a start pulse it reads a block of words through the OCD memory-read port (ocd_read_enable / ocd_rw_addr / ocd_mem_enable_out / ocd_mem_word_out).
- It serializes the words as a checksummed frame on the debug UART TX (8N1).
- Sits beside the hardware loader in the board top. It owns the TX mux while busy.

Parameters:
- BAUD_PERIOD, 217, clocks per UART bit (MCU_MAIN_CLK_RATE / DEBUG_UART_BAUD).
- ADDR_WIDTH, 14, word-address width (MEM_ADDR_BITS).
- XLEN, 32, word width; must be 32.
- READ_TIMEOUT, 15, max clocks to wait for mem_enable_in after a read request.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- start  in  1  one-cycle request to begin a dump
- start_addr  in  ADDR_WIDTH  first word address
- word_count  in  16  number of words to dump
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse at frame end
- read_error  out  1  sticky: at least one read timed out in the last dump
- mem_read_enable  out  1  one-cycle read request
- mem_read_addr  out  ADDR_WIDTH  read word address
- mem_enable_in  in  1  read data valid
- mem_word_in  in  XLEN  read data
- TXD  out  1  UART serial out, idle high
- uart_tx_sel_dump  out  1  high while the block owns the TX line

Behaviour:
- Reset (reset_n low at a clk edge, including mid-frame): all outputs return to reset values on that edge. TXD=1, busy=0, done=0, read_error=0, mem_read_enable=0, mem_read_addr=0, uart_tx_sel_dump=0. The frame in progress is abandoned; no partial byte continues.
- start is accepted only in IDLE. start while busy is ignored.
- On accept:
  - latch start_addr and word_count;
  - clear read_error and the checksum;
  - set busy=1 and uart_tx_sel_dump=1 on the next cycle.
- FSM states: IDLE -> SYNC -> [HDR] -> REQ -> WAIT -> SEND -> (REQ | CSUM) -> FIN -> IDLE.
  - SYNC: transmit byte 0x5A. It is not included in the checksum.
  - REQ: assert mem_read_enable for exactly 1 cycle with mem_read_addr = current address.
  - WAIT: capture mem_word_in on the first cycle mem_enable_in=1.
    - If mem_enable_in has not arrived READ_TIMEOUT cycles after REQ, substitute 32'hDEADBEEF and set read_error=1.
    - mem_enable_in outside WAIT is ignored.
  - SEND: transmit the 4 bytes little-endian. Add each byte to the checksum. Increment the address modulo 2^ADDR_WIDTH (0x3FFF wraps to 0x0000). Decrement the remaining count; if nonzero go to REQ, else go to CSUM.
  - word_count=0: go SYNC -> CSUM directly, sending 5A 00.
  - CSUM: transmit the checksum = 8-bit sum of all non-sync bytes, mod 256.
  - FIN: done=1 for 1 cycle, busy=0 and uart_tx_sel_dump=0 in the same cycle, then IDLE.
- UART byte format:
  - start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly BAUD_PERIOD clocks;
  - one byte = 10*BAUD_PERIOD clocks;
  - consecutive bytes of a frame are back-to-back, with no idle gap beyond the next byte's start;
  - TXD is registered.
- Inter-word gap: TXD stays high during REQ/WAIT (at most READ_TIMEOUT+2 clocks).

Optional Feature:
- Macro DUMP_ADDR_HEADER_EN.
- When defined, the HDR state follows SYNC and sends start_addr zero-extended to 32 bits (4 bytes LE), then word_count (2 bytes LE). All 6 bytes are included in the checksum.
- When undefined, HDR does not exist and SYNC goes straight to REQ (or CSUM if the count is 0).

Test Plan:
- Memory model with 1-cycle latency holds 0x04030201 at 0x0010 and 0x08070605 at 0x0011; start, addr 0x0010, count 2. Required response: TXD bytes 5A 01 02 03 04 05 06 07 08 24, done pulse once, read_error=0, busy high for the whole frame.
- Same with DUMP_ADDR_HEADER_EN. Required response: 5A 10 00 00 00 02 00 01..08 36.
- count=0, addr 0x0005. Required response: bytes 5A 00, exactly 2 bytes, no mem_read_enable.
- addr 0x3FFF, count 2. Required response: reads at 0x3FFF then 0x0000.
- Memory never asserts mem_enable_in, count 1. Required response: bytes 5A EF BE AD DE 38 (0xEF+0xBE+0xAD+0xDE mod 256), read_error=1 after done.
- start pulsed again mid-frame: ignored, frame unchanged. reset_n low during byte 3: next edge TXD=1, busy=0, uart_tx_sel_dump=0; a new start after release produces a complete frame.
